// File: rtl/hazard_unit_pkg.sv
// Shared types for the decode-stage hazard unit: control levels, register addresses, shadow entries.
// No logic here beyond a small liveness helper used by the comparator.
package hazard_unit_pkg;

    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] RegAddr;

    typedef enum logic {
        DISABLE = 1'b0,
        ENABLE  = 1'b1
    } Signal;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } HazState;

    typedef struct packed {
        logic   valid;
        RegAddr dest;
        logic   wr;
        logic   ld;
    } ShadowEntry;

    // Register 0 is hardwired, so a write to it never produces a value worth forwarding.
    function automatic logic entry_live(input ShadowEntry e);
        return e.valid & e.wr & (e.dest != '0);
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Compares decode-stage source operands against one shadow pipeline entry.
// Purely combinational; no state, no backpressure.
module hazard_cmp
    import hazard_unit_pkg::*;
(
    input  ShadowEntry ent,
    input  RegAddr     rs_a,
    input  RegAddr     rt_a,
    input  logic       uses_rt,
    output logic       match_rs,
    output logic       match_rt
);

    logic live;

    always_comb begin
        live     = entry_live(ent);
        match_rs = live & (ent.dest == rs_a);
        match_rt = live & uses_rt & (ent.dest == rt_a);
    end

endmodule

// File: rtl/hazard_unit.sv
// Forwarding selects, load-use stall and branch/jump flush control for the decode/execute boundary.
// Outputs are combinational from shadow state and decode inputs; state advances every posedge.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int BRANCH_PENALTY = 2
)
(
    input  logic   clk,
    input  logic   rst,
    input  RegAddr rs_a,
    input  RegAddr rt_a,
    input  RegAddr rd_a,
    input  logic   reg_dst,
    input  logic   uses_rt,
    input  logic   reg_write,
    input  logic   read_mem,
    input  logic   jmp,
    input  logic   branch_taken,
    output Signal  fwdX_rs,
    output Signal  fwdX_rt,
    output Signal  fwdM_rs,
    output Signal  fwdM_rt,
    output Signal  stall,
    output logic   pc_hold,
    output logic   flush_fd
);

    localparam logic [2:0] CNT_RELOAD = 3'(BRANCH_PENALTY - 1);

    HazState    state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    ShadowEntry shx_q, shx_d;
    ShadowEntry shm_q, shm_d;

    ShadowEntry dec_entry;
    logic       x_rs, x_rt, m_rs, m_rt;
    logic       load_hz;
    logic       flush_act;
    logic       advance;

    hazard_cmp u_cmp_x (
        .ent      (shx_q),
        .rs_a     (rs_a),
        .rt_a     (rt_a),
        .uses_rt  (uses_rt),
        .match_rs (x_rs),
        .match_rt (x_rt)
    );

    hazard_cmp u_cmp_m (
        .ent      (shm_q),
        .rs_a     (rs_a),
        .rt_a     (rt_a),
        .uses_rt  (uses_rt),
        .match_rs (m_rs),
        .match_rt (m_rt)
    );

    always_comb begin
        dec_entry.valid = 1'b1;
        dec_entry.dest  = reg_dst ? rd_a : rt_a;
        dec_entry.wr    = reg_write;
        dec_entry.ld    = read_mem;
    end

    // Hazard priority: active flush beats load-use, load-use beats jump.
    always_comb begin
        flush_act = branch_taken | (state_q == FLUSH);
        load_hz   = shx_q.ld & (x_rs | x_rt);

        advance  = 1'b1;
        pc_hold  = 1'b0;
        flush_fd = 1'b0;

        if (flush_act) begin
            advance  = 1'b0;
            flush_fd = 1'b1;
        end else if (load_hz) begin
            advance = 1'b0;
            pc_hold = 1'b1;
        end else if (jmp) begin
            flush_fd = 1'b1;
        end

        fwdX_rs = (x_rs & ~shx_q.ld) ? ENABLE : DISABLE;
        fwdX_rt = (x_rt & ~shx_q.ld) ? ENABLE : DISABLE;
        fwdM_rs = m_rs ? ENABLE : DISABLE;
        fwdM_rt = m_rt ? ENABLE : DISABLE;
        stall   = advance ? ENABLE : DISABLE;

        if (rst) begin
            advance  = 1'b1;
            pc_hold  = 1'b0;
            flush_fd = 1'b0;
            fwdX_rs  = DISABLE;
            fwdX_rt  = DISABLE;
            fwdM_rs  = DISABLE;
            fwdM_rt  = DISABLE;
            stall    = ENABLE;
        end
    end

    // Counter holds the number of FLUSH-state cycles still owed after the trigger cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            RUN: begin
                if (branch_taken && BRANCH_PENALTY > 1) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_RELOAD;
                end
            end
            FLUSH: begin
                if (branch_taken) begin
                    cnt_d = CNT_RELOAD;
                    if (BRANCH_PENALTY <= 1) begin
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_d == 3'd0) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // MEM always advances; EX takes the decode instruction or a bubble.
    always_comb begin
        shm_d = shx_q;
        shx_d = advance ? dec_entry : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
            shx_q   <= '0;
            shm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shx_q   <= shx_d;
            shm_q   <= shm_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed plus randomized checks of hazard_unit against an instruction-level pipeline model.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int P = 2;

    logic   clk = 1'b0;
    logic   rst;
    RegAddr rs_a, rt_a, rd_a;
    logic   reg_dst, uses_rt, reg_write, read_mem, jmp, branch_taken;
    Signal  fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt, stall;
    logic   pc_hold, flush_fd;

    hazard_unit #(.BRANCH_PENALTY(P)) dut (
        .clk          (clk),
        .rst          (rst),
        .rs_a         (rs_a),
        .rt_a         (rt_a),
        .rd_a         (rd_a),
        .reg_dst      (reg_dst),
        .uses_rt      (uses_rt),
        .reg_write    (reg_write),
        .read_mem     (read_mem),
        .jmp          (jmp),
        .branch_taken (branch_taken),
        .fwdX_rs      (fwdX_rs),
        .fwdX_rt      (fwdX_rt),
        .fwdM_rs      (fwdM_rs),
        .fwdM_rt      (fwdM_rt),
        .stall        (stall),
        .pc_hold      (pc_hold),
        .flush_fd     (flush_fd)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] d;
        bit       w;
        bit       l;
    } ins_t;

    int   checks = 0;
    int   errors = 0;
    ins_t ex_m, mem_m;
    int   flush_left = 0;

    function automatic bit writes_reg(input ins_t e);
        return e.v && e.w && (e.d != 5'd0);
    endfunction

    task automatic model_out(output bit fxr, output bit fxt, output bit fmr, output bit fmt,
                             output bit st, output bit ph, output bit ff);
        bit lhz, fl;
        fxr = writes_reg(ex_m) && !ex_m.l && ex_m.d == rs_a;
        fxt = writes_reg(ex_m) && !ex_m.l && uses_rt && ex_m.d == rt_a;
        fmr = writes_reg(mem_m) && mem_m.d == rs_a;
        fmt = writes_reg(mem_m) && uses_rt && mem_m.d == rt_a;
        lhz = writes_reg(ex_m) && ex_m.l && (ex_m.d == rs_a || (uses_rt && ex_m.d == rt_a));
        fl  = branch_taken || flush_left > 0;
        st  = !(fl || lhz);
        ph  = lhz && !fl;
        ff  = fl || (!lhz && jmp);
        if (rst) begin
            fxr = 0; fxt = 0; fmr = 0; fmt = 0; st = 1; ph = 0; ff = 0;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        bit fxr, fxt, fmr, fmt, st, ph, ff;
        model_out(fxr, fxt, fmr, fmt, st, ph, ff);
        chk("fwdX_rs", fwdX_rs, fxr);
        chk("fwdX_rt", fwdX_rt, fxt);
        chk("fwdM_rs", fwdM_rs, fmr);
        chk("fwdM_rt", fwdM_rt, fmt);
        chk("stall", stall, st);
        chk("pc_hold", pc_hold, ph);
        chk("flush_fd", flush_fd, ff);
    endtask

    task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic rdst, input logic urt, input logic rw, input logic rm,
                         input logic j, input logic br);
        rst = r; rs_a = rs; rt_a = rt; rd_a = rd; reg_dst = rdst; uses_rt = urt;
        reg_write = rw; read_mem = rm; jmp = j; branch_taken = br;
        #1;
        check_model();
    endtask

    task automatic advance();
        bit fxr, fxt, fmr, fmt, st, ph, ff;
        model_out(fxr, fxt, fmr, fmt, st, ph, ff);
        @(posedge clk);
        if (rst) begin
            ex_m = '{default: 0};
            mem_m = '{default: 0};
            flush_left = 0;
        end else begin
            mem_m = ex_m;
            if (st) ex_m = '{1'b1, reg_dst ? rd_a : rt_a, reg_write, read_mem};
            else    ex_m = '{default: 0};
            if (branch_taken)        flush_left = P - 1;
            else if (flush_left > 0) flush_left--;
        end
        @(negedge clk);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        drive(0, rs, rt, rd, 1, 1, 1, 0, 0, 0);
    endtask

    task automatic lw(input logic [4:0] rt, input logic [4:0] rs);
        drive(0, rs, rt, 5'd0, 0, 0, 1, 1, 0, 0);
    endtask

    task automatic nop_br(input logic br, input logic r);
        drive(r, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, br);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ex_m = '{default: 0};
        mem_m = '{default: 0};
        nop_br(0, 1);
        chk("reset_stall", stall, 1'b1);
        chk("reset_flush", flush_fd, 1'b0);
        advance();
        nop_br(1, 1);
        chk("reset_br_flush", flush_fd, 1'b0);
        advance();
        nop_br(0, 0);
        chk("post_reset_flush", flush_fd, 1'b0);
        advance();

        // add $3 ; sub $4,$3,$5
        alu(5'd3, 5'd1, 5'd2); advance();
        alu(5'd4, 5'd3, 5'd5);
        chk("plan1_fwdX_rs", fwdX_rs, 1'b1);
        chk("plan1_fwdM_rs", fwdM_rs, 1'b0);
        chk("plan1_stall", stall, 1'b1);
        advance();

        // add $3 ; add $3 ; or $6,$3,$3
        alu(5'd3, 5'd1, 5'd2); advance();
        alu(5'd3, 5'd1, 5'd2); advance();
        alu(5'd6, 5'd3, 5'd3);
        chk("plan2_fwdX_rs", fwdX_rs, 1'b1);
        chk("plan2_fwdX_rt", fwdX_rt, 1'b1);
        chk("plan2_fwdM_rs", fwdM_rs, 1'b1);
        chk("plan2_fwdM_rt", fwdM_rt, 1'b1);
        advance();

        // lw $2 ; add $7,$2,$1
        lw(5'd2, 5'd9); advance();
        alu(5'd7, 5'd2, 5'd1);
        chk("plan3_stall", stall, 1'b0);
        chk("plan3_pc_hold", pc_hold, 1'b1);
        advance();
        alu(5'd7, 5'd2, 5'd1);
        chk("plan3_fwdM_rs", fwdM_rs, 1'b1);
        chk("plan3_fwdX_rs", fwdX_rs, 1'b0);
        chk("plan3_pc_hold2", pc_hold, 1'b0);
        advance();

        // write $0, then read $0
        alu(5'd0, 5'd1, 5'd2); advance();
        alu(5'd0, 5'd1, 5'd2); advance();
        alu(5'd8, 5'd0, 5'd0);
        chk("plan4_fwdX_rs", fwdX_rs, 1'b0);
        chk("plan4_fwdM_rt", fwdM_rt, 1'b0);
        advance();

        // branch pulse, then second pulse inside the flush window
        nop_br(1, 0); chk("br_c0", flush_fd, 1'b1); advance();
        nop_br(0, 0); chk("br_c1", flush_fd, 1'b1); advance();
        nop_br(0, 0); chk("br_c2", flush_fd, 1'b0); advance();
        nop_br(1, 0); advance();
        nop_br(1, 0); chk("br_re1", flush_fd, 1'b1); advance();
        nop_br(0, 0); chk("br_re2", flush_fd, 1'b1); advance();
        nop_br(0, 0); chk("br_re3", stall, 1'b1); advance();

        // reset in the middle of a flush
        nop_br(1, 0); advance();
        nop_br(0, 1); advance();
        nop_br(0, 0); chk("rst_flush", flush_fd, 1'b0); advance();

        // jump behind a load it depends on
        lw(5'd2, 5'd9); advance();
        drive(0, 5'd2, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);
        chk("jmp_c1_stall", stall, 1'b0);
        chk("jmp_c1_flush", flush_fd, 1'b0);
        advance();
        drive(0, 5'd2, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);
        chk("jmp_c2_flush", flush_fd, 1'b1);
        chk("jmp_c2_stall", stall, 1'b1);
        advance();

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 59) == 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Produces the forwarding selects and the stall/bubble control consumed by the decode/execute pipeline register. These are fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt and stall.
- Keeps a shadow copy of the destination register of the instructions now in the EX and MEM stages. Compares both against the source operands being decoded.
- Detects load-use hazards and runs the control-hazard flush after a taken branch or a jump.

Parameters:
BRANCH_PENALTY, 2, cycles of fetch/decode flush after branch_taken (1..7)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
rs_a  in  RegAddr  decode-stage rs address
rt_a  in  RegAddr  decode-stage rt address
rd_a  in  RegAddr  decode-stage rd address
reg_dst  in  1  1: destination is rd_a, 0: destination is rt_a
uses_rt  in  1  decode instruction reads rt (R-type, store, branch)
reg_write  in  1  decode instruction writes a register
read_mem  in  1  decode instruction is a load
jmp  in  1  decode instruction is a jump
branch_taken  in  1  branch resolved taken in EX this cycle
fwdX_rs  out  Signal  select EX-stage result for rs
fwdX_rt  out  Signal  select EX-stage result for rt
fwdM_rs  out  Signal  select MEM-stage result for rs
fwdM_rt  out  Signal  select MEM-stage result for rt
stall  out  Signal  ENABLE: DX register advances; DISABLE: DX inserts bubble (clears reg_write/write_mem)
pc_hold  out  1  freeze PC and FD register this cycle
flush_fd  out  1  replace FD register contents with a NOP at next edge

Behaviour:
- Shadow entries shX and shM each hold {valid, dest, wr, ld}.
  - dest = reg_dst ? rd_a : rt_a.
  - An entry is "live" when valid & wr & dest != 0.
- Per posedge:
  - shM <= shX, unconditionally; MEM never holds.
  - shX <= decode entry when stall == ENABLE; otherwise shX <= invalid, mirroring the DX bubble.
- Reset: shX, shM invalid; state RUN; counter 0.
  - Outputs during and after reset until new state: all fwd* = DISABLE, stall = ENABLE, pc_hold = 0, flush_fd = 0.
- Forwarding (combinational from shadow plus decode inputs):
  - fwdX_rs = ENABLE iff shX live & shX.dest == rs_a & !shX.ld.
  - fwdM_rs = ENABLE iff shM live & shM.dest == rs_a.
  - rt versions are the same, additionally gated by uses_rt.
  - X and M may both be ENABLE. The consumer gives X priority, so the newest value wins.
  - Register 0 is never forwarded.
- Load-use: load_hz = shX live & shX.ld & (shX.dest == rs_a | (uses_rt & shX.dest == rt_a)).
  - When load_hz: stall = DISABLE, pc_hold = 1, for exactly one cycle.
  - Next cycle the load sits in shM, and the fwdM_* path supplies the data.
- FSM states: RUN, FLUSH.
  - RUN -> FLUSH on branch_taken; counter <= BRANCH_PENALTY-1.
  - FLUSH: flush_fd = 1 and stall = DISABLE every cycle. Counter decrements; leave to RUN when counter == 0.
  - On the branch_taken cycle itself (in RUN), flush_fd = 1 and stall = DISABLE.
  - Total flush length is BRANCH_PENALTY cycles including the trigger cycle.
  - branch_taken while in FLUSH reloads the counter (restart).
- Jump: jmp in RUN with no load_hz gives flush_fd = 1 for one cycle. stall stays ENABLE, because the jump itself proceeds.
- Priority: branch_taken/FLUSH > load_hz > jmp.
  - A load_hz coinciding with a flush is ignored, since the decode instruction is wrong-path. pc_hold = 0 in that case.
  - jmp under load_hz waits; the flush fires on the cycle the jump advances.
- stall == DISABLE always implies fwd* values are don't-care downstream, but they are still computed per the rules above.
- rst asserted mid-FLUSH or mid-load-stall returns to the reset state at that edge; no residual flush.

Decomposition:
- Package additions next to Signal/RegAddr: typedef enum HazState {RUN, FLUSH}; typedef struct packed ShadowEntry {valid, dest, wr, ld}.
- One natural sub-module: hazard_cmp. Combinational source-vs-shadow comparator, instantiated for X and M; outputs match_rs, match_rt.

Test Plan:
- add $3 followed by sub $4,$3,$5 -> cycle 2: fwdX_rs = ENABLE, fwdM_rs = DISABLE, stall = ENABLE.
- add $3; add $3; or $6,$3,$3 -> fwdX_rs = fwdX_rt = ENABLE and fwdM_rs = fwdM_rt = ENABLE in the same cycle.
- lw $2; add $7,$2,$1 -> one cycle stall = DISABLE, pc_hold = 1; next cycle fwdM_rs = ENABLE, fwdX_rs = DISABLE.
- Write to $0, then a read of $0 -> all fwd* = DISABLE.
- branch_taken pulse, BRANCH_PENALTY = 2 -> flush_fd = 1 and stall = DISABLE for exactly 2 cycles, then RUN.
  - Second pulse during FLUSH -> 2 more cycles.
  - rst during FLUSH -> flush_fd = 0 at the next cycle.
- jmp with concurrent load_hz -> cycle 1: stall = DISABLE, flush_fd = 0; cycle 2: flush_fd = 1, stall = ENABLE.
